// File: rtl/pipelined_addsub_pkg.sv
// ALU control codes and the add/subtract decode shared with the ALU decoder.
package pipelined_addsub_pkg;

   localparam logic [3:0] ALU_CTRL_SUB     = 4'b0101;
   localparam logic [1:0] ALU_CTRL_SUB_GRP = 2'b11;

   function automatic logic is_sub(input logic [3:0] ctrl);
      return (ctrl == ALU_CTRL_SUB) || (ctrl[3:2] == ALU_CTRL_SUB_GRP);
   endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle between ALU control decode and the adder pipe.
interface pipelined_addsub_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       ctrl;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] res;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, ctrl, out_ready,
      input  in_ready, out_valid, res, cout, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, ctrl, out_ready,
      output in_ready, out_valid, res, cout, ovf, zero
   );
endinterface

// File: rtl/pipelined_addsub_seg.sv
// Full-adder cell and the SEG-bit combinational ripple segment built from it.
module fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module addsub_seg #(
   parameter int SEG = 8
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           cin,
   output logic [SEG-1:0] sum,
   output logic           cout
);
   logic [SEG:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < SEG; i++) begin : g_bit
      fa u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (c[i]),
         .sum  (sum[i]),
         .cout (c[i+1])
      );
   end

   assign cout = c[SEG];
endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: WIDTH-bit carry chain split into STAGES registered ripple segments.
module pipelined_addsub
   import pipelined_addsub_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input logic               clk,
   input logic               rst,
   pipelined_addsub_if.slave bus
);
   localparam int SEG = WIDTH / STAGES;

   logic [WIDTH-1:0] a_q     [STAGES];
   logic [WIDTH-1:0] a_d     [STAGES];
   logic [WIDTH-1:0] b_q     [STAGES];
   logic [WIDTH-1:0] b_d     [STAGES];
   logic [WIDTH-1:0] res_q   [STAGES];
   logic [WIDTH-1:0] res_d   [STAGES];
   logic             carry_q [STAGES];
   logic             carry_d [STAGES];
   logic             zero_q  [STAGES];
   logic             zero_d  [STAGES];
   logic             sa_q    [STAGES];
   logic             sa_d    [STAGES];
   logic             sb_q    [STAGES];
   logic             sb_d    [STAGES];
   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] v_d;

   logic [SEG-1:0] seg_a   [STAGES];
   logic [SEG-1:0] seg_b   [STAGES];
   logic [SEG-1:0] seg_sum [STAGES];
   logic           seg_ci  [STAGES];
   logic           seg_co  [STAGES];

   logic             advance;
   logic             accept;
   logic             sub;
   logic [WIDTH-1:0] b_eff;

   // Whole pipe moves as one; no bubble squeezing.
   assign advance      = !v_q[STAGES-1] || bus.out_ready;
   assign bus.in_ready = advance;
   assign accept       = bus.in_valid && advance;
   assign sub          = is_sub(bus.ctrl);
   assign b_eff        = sub ? ~bus.b : bus.b;

   always_comb begin
      seg_a[0]  = bus.a[SEG-1:0];
      seg_b[0]  = b_eff[SEG-1:0];
      seg_ci[0] = sub;
      for (int k = 1; k < STAGES; k++) begin
         seg_a[k]  = a_q[k-1][k*SEG +: SEG];
         seg_b[k]  = b_q[k-1][k*SEG +: SEG];
         seg_ci[k] = carry_q[k-1];
      end
   end

   for (genvar g = 0; g < STAGES; g++) begin : g_seg
      addsub_seg #(.SEG(SEG)) u_seg (
         .a    (seg_a[g]),
         .b    (seg_b[g]),
         .cin  (seg_ci[g]),
         .sum  (seg_sum[g]),
         .cout (seg_co[g])
      );
   end

   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      zero_d  = zero_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      v_d     = v_q;
      if (advance) begin
         v_d[0]              = accept;
         a_d[0]              = bus.a;
         b_d[0]              = b_eff;
         res_d[0]            = '0;
         res_d[0][SEG-1:0]   = seg_sum[0];
         carry_d[0]          = seg_co[0];
         zero_d[0]           = (seg_sum[0] == '0);
         sa_d[0]             = bus.a[WIDTH-1];
         sb_d[0]             = b_eff[WIDTH-1];
         for (int k = 1; k < STAGES; k++) begin
            v_d[k]                 = v_q[k-1];
            a_d[k]                 = a_q[k-1];
            b_d[k]                 = b_q[k-1];
            res_d[k]               = res_q[k-1];
            res_d[k][k*SEG +: SEG] = seg_sum[k];
            carry_d[k]             = seg_co[k];
            zero_d[k]              = zero_q[k-1] && (seg_sum[k] == '0);
            sa_d[k]                = sa_q[k-1];
            sb_d[k]                = sb_q[k-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]     <= '0;
            b_q[k]     <= '0;
            res_q[k]   <= '0;
            carry_q[k] <= 1'b0;
            zero_q[k]  <= 1'b0;
            sa_q[k]    <= 1'b0;
            sb_q[k]    <= 1'b0;
         end
      end else begin
         v_q     <= v_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
      end
   end

   assign bus.out_valid = v_q[STAGES-1];
   assign bus.res       = res_q[STAGES-1];
   assign bus.cout      = carry_q[STAGES-1];
   assign bus.zero      = zero_q[STAGES-1];
   assign bus.ovf       = (sa_q[STAGES-1] == sb_q[STAGES-1]) &&
                          (res_q[STAGES-1][WIDTH-1] != sa_q[STAGES-1]);
endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub at STAGES = 1, 4 and 32 sharing one stimulus.
module tb_pipelined_addsub;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [3:0]  ctrl = '0;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   int n_out = 0;
   int first_out = -1;
   int last_out = -1;
   logic [34:0] q[$];

   always #5 clk = ~clk;

   pipelined_addsub_if #(.WIDTH(32)) if1 ();
   pipelined_addsub_if #(.WIDTH(32)) if4 ();
   pipelined_addsub_if #(.WIDTH(32)) if32 ();

   assign if1.in_valid  = in_valid;
   assign if1.a         = a;
   assign if1.b         = b;
   assign if1.ctrl      = ctrl;
   assign if1.out_ready = out_ready;
   assign if4.in_valid  = in_valid;
   assign if4.a         = a;
   assign if4.b         = b;
   assign if4.ctrl      = ctrl;
   assign if4.out_ready = out_ready;
   assign if32.in_valid  = in_valid;
   assign if32.a         = a;
   assign if32.b         = b;
   assign if32.ctrl      = ctrl;
   assign if32.out_ready = out_ready;

   pipelined_addsub #(.WIDTH(32), .STAGES(1))  dut1  (.clk(clk), .rst(rst), .bus(if1));
   pipelined_addsub #(.WIDTH(32), .STAGES(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));
   pipelined_addsub #(.WIDTH(32), .STAGES(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: plain wide arithmetic, overflow from the true signed result.
   function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y,
                                         input logic [3:0] c);
      logic        s;
      logic [32:0] full;
      longint      sx, sy, sr;
      logic        ov;
      s    = (c == 4'b0101) || (c[3:2] == 2'b11);
      full = s ? ({1'b0, x} + {1'b0, ~y} + 33'd1) : ({1'b0, x} + {1'b0, y});
      sx   = longint'($signed(x));
      sy   = longint'($signed(y));
      sr   = s ? sx - sy : sx + sy;
      ov   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      return {full[32], ov, full[31:0] == 32'd0, full[31:0]};
   endfunction

   task automatic run_single(input string name, input logic [31:0] x, input logic [31:0] y,
                             input logic [3:0] c, input logic [34:0] exp);
      int          lat1 = 0, lat4 = 0, lat32 = 0;
      logic [34:0] o1 = '0, o4 = '0, o32 = '0;
      a = x; b = y; ctrl = c; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         if (if1.out_valid && lat1 == 0) begin
            lat1 = n; o1 = {if1.cout, if1.ovf, if1.zero, if1.res};
         end
         if (if4.out_valid && lat4 == 0) begin
            lat4 = n; o4 = {if4.cout, if4.ovf, if4.zero, if4.res};
         end
         if (if32.out_valid && lat32 == 0) begin
            lat32 = n; o32 = {if32.cout, if32.ovf, if32.zero, if32.res};
         end
         @(posedge clk); #1;
      end
      chk({name, "_s1_lat"}, lat1, 1);
      chk({name, "_s1_out"}, o1, exp);
      chk({name, "_s4_lat"}, lat4, 4);
      chk({name, "_s4_out"}, o4, exp);
      chk({name, "_s32_lat"}, lat32, 32);
      chk({name, "_s32_out"}, o32, exp);
   endtask

   // One cycle on the STAGES=4 unit: score the presented result, record accepts.
   task automatic step(input string tag);
      @(negedge clk);
      if (if4.out_valid) begin
         if (q.size() == 0) begin
            chk({tag, "_spurious"}, 1, 0);
         end else begin
            chk(tag, {if4.cout, if4.ovf, if4.zero, if4.res}, q[0]);
            if (out_ready) begin
               void'(q.pop_front());
               n_out++;
               if (first_out < 0) first_out = cyc;
               last_out = cyc;
            end
         end
      end
      if (in_valid && if4.in_ready) q.push_back(model(a, b, ctrl));
      @(posedge clk); #1;
      cyc++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int stale;

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_out_valid", if4.out_valid, 0);
      chk("rst_res", if4.res, 0);
      chk("rst_flags", {if4.cout, if4.ovf, if4.zero}, 0);
      chk("rst_in_ready", if4.in_ready, 1);
      chk("rst_s1_out_valid", if1.out_valid, 0);
      chk("rst_s32_out_valid", if32.out_valid, 0);

      run_single("add_5_3",    32'd5,          32'd3, 4'b0000, {1'b0, 1'b0, 1'b0, 32'd8});
      run_single("add_ovf",    32'h7FFF_FFFF,  32'd1, 4'b0000, {1'b0, 1'b1, 1'b0, 32'h8000_0000});
      run_single("add_wrap",   32'hFFFF_FFFF,  32'd1, 4'b0000, {1'b1, 1'b0, 1'b1, 32'h0000_0000});
      run_single("sub_0101",   32'h1234_5678,  32'h1234_5678, 4'b0101, {1'b1, 1'b0, 1'b1, 32'h0});
      run_single("sub_1110",   32'h1234_5678,  32'h1234_5678, 4'b1110, {1'b1, 1'b0, 1'b1, 32'h0});
      run_single("sub_borrow", 32'd0,          32'd1, 4'b1100, {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF});
      run_single("sub_ovf",    32'h8000_0000,  32'd1, 4'b1100, {1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF});

      // Back-to-back stream at full throughput.
      q.delete(); n_out = 0; first_out = -1; last_out = -1;
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         a = $urandom; b = $urandom; ctrl = 4'($urandom_range(0, 15));
         if (i == 3) begin a = 32'h7FFF_FFFF; b = 32'h8000_0000; ctrl = 4'b0101; end
         in_valid = 1'b1;
         step("stream");
      end
      in_valid = 1'b0;
      for (int i = 0; i < 20 && n_out < 16; i++) step("stream");
      chk("stream_count", n_out, 16);
      chk("stream_span", last_out - first_out, 15);
      chk("stream_q_empty", q.size(), 0);

      // Fill the pipe, stall the consumer, then release.
      q.delete(); n_out = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a = $urandom; b = $urandom; ctrl = (i[0]) ? 4'b1101 : 4'b0010;
         in_valid = 1'b1;
         step("fill");
      end
      a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; ctrl = 4'b0101; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("stall_in_ready", if4.in_ready, 0);
         chk("stall_out_valid", if4.out_valid, 1);
         step("stall_hold");
      end
      out_ready = 1'b1;
      step("drain");
      in_valid = 1'b0;
      for (int i = 0; i < 20 && n_out < 5; i++) step("drain");
      chk("drain_count", n_out, 5);
      chk("drain_q_empty", q.size(), 0);

      // Reset with three ops in flight.
      q.delete();
      for (int i = 0; i < 3; i++) begin
         a = 32'd100 + 32'(i); b = 32'd7; ctrl = 4'b0000; in_valid = 1'b1;
         step("preload");
      end
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_s4_out_valid", if4.out_valid, 0);
      chk("midrst_s1_out_valid", if1.out_valid, 0);
      chk("midrst_s32_out_valid", if32.out_valid, 0);
      rst = 1'b0;
      stale = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (if1.out_valid || if4.out_valid || if32.out_valid) stale++;
      end
      chk("no_stale", stale, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
